// File: rtl/seq_addsub_unit.sv
// seq_addsub_unit: digit-serial two's-complement adder/subtractor with
// carry chaining, overflow/zero/negative flags and a start/busy/done handshake.
module seq_addsub_unit #(
    parameter int unsigned WIDTH = 16,
    parameter int unsigned DIGIT = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic             cin,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             cout,
    output logic             ovf,
    output logic             zero,
    output logic             neg
);

    localparam int unsigned N  = WIDTH / DIGIT;
    localparam int unsigned CW = (N > 1) ? $clog2(N) : 1;
    localparam int unsigned DW = DIGIT + 1;

    // Reject illegal parameter combinations at elaboration
    generate
        if (WIDTH < 2 || DIGIT < 1 || DIGIT > WIDTH || (WIDTH % DIGIT) != 0) begin : g_bad_param
            $error("seq_addsub_unit: illegal WIDTH/DIGIT combination");
        end
    endgenerate

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state;
    state_t           next_state;
    logic             busy_d;
    logic             done_d;

    logic [WIDTH-1:0] a_sr;
    logic [WIDTH-1:0] b_sr;
    logic [WIDTH-1:0] res_sr;
    logic             carry;
    logic [CW-1:0]    cnt;

    logic             accept;
    logic             last_digit;
    logic [DIGIT:0]   digit_sum;
    logic             msb_cin;
    logic [WIDTH+DIGIT-1:0] res_cat;
    logic [WIDTH-1:0] res_next;

    assign accept     = start && (state == IDLE || state == DONE);
    assign last_digit = (state == RUN) && (cnt == CW'(N - 1));

    // One ripple slice: low digit of each operand plus the running carry
    assign digit_sum = {1'b0, a_sr[DIGIT-1:0]} + {1'b0, b_sr[DIGIT-1:0]} + DW'(carry);
    // Carry into the top bit of this digit; on the last digit it is the carry into the MSB
    assign msb_cin   = digit_sum[DIGIT-1] ^ a_sr[DIGIT-1] ^ b_sr[DIGIT-1];
    assign res_cat   = {digit_sum[DIGIT-1:0], res_sr};
    assign res_next  = WIDTH'(res_cat >> DIGIT);

    // State register plus registered handshake outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            busy  <= 1'b0;
            done  <= 1'b0;
        end else begin
            state <= next_state;
            busy  <= busy_d;
            done  <= done_d;
        end
    end

    // Next-state logic
    always_comb begin
        next_state = state;
        case (state)
            IDLE:    next_state = start ? RUN : IDLE;
            RUN:     next_state = last_digit ? DONE : RUN;
            DONE:    next_state = start ? RUN : IDLE;
            default: next_state = IDLE;
        endcase
    end

    // Handshake outputs decoded from the upcoming state, registered above
    always_comb begin
        busy_d = 1'b0;
        done_d = 1'b0;
        if (next_state == RUN)  busy_d = 1'b1;
        if (next_state == DONE) done_d = 1'b1;
    end

    // Operand/result shift registers, carry and digit counter
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_sr   <= '0;
            b_sr   <= '0;
            res_sr <= '0;
            carry  <= 1'b0;
            cnt    <= '0;
        end else if (accept) begin
            a_sr   <= a;
            b_sr   <= op[0] ? ~b : b;
            res_sr <= '0;
            carry  <= op[1] ? cin : op[0];
            cnt    <= '0;
        end else if (state == RUN) begin
            a_sr   <= a_sr >> DIGIT;
            b_sr   <= b_sr >> DIGIT;
            res_sr <= res_next;
            carry  <= digit_sum[DIGIT];
            cnt    <= cnt + CW'(1);
        end
    end

    // Result and flags update only on the edge that enters DONE
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            result <= '0;
            cout   <= 1'b0;
            ovf    <= 1'b0;
            zero   <= 1'b0;
            neg    <= 1'b0;
        end else if (last_digit) begin
            result <= res_next;
            cout   <= digit_sum[DIGIT];
            ovf    <= msb_cin ^ digit_sum[DIGIT];
            zero   <= (res_next == '0);
            neg    <= res_next[WIDTH-1];
        end
    end

endmodule

// File: tb/tb_seq_addsub_unit.sv
// tb_seq_addsub_unit: directed and random checks of seq_addsub_unit across
// four WIDTH/DIGIT configurations, with an expected-result queue.
module tb_seq_addsub_unit;

    typedef struct {
        logic [31:0] res;
        logic        cout;
        logic        ovf;
        logic        zero;
        logic        neg;
    } exp_t;

    localparam int W_CFG [4] = '{16, 16, 16, 32};
    localparam int N_CFG [4] = '{4, 16, 1, 4};

    logic        clk;
    logic        rst_n;
    logic [3:0]  start_v;
    logic [1:0]  op;
    logic        cin;
    logic [31:0] a;
    logic [31:0] b;
    logic [3:0]  busy_v, done_v, cout_v, ovf_v, zero_v, neg_v;
    logic [15:0] res0, res1, res2;
    logic [31:0] res3;
    logic [31:0] res_k [4];

    int checks;
    int errors;
    int cyc_cnt;
    int acc_cyc;
    exp_t sb [$];

    seq_addsub_unit #(.WIDTH(16), .DIGIT(4)) u_d4 (
        .clk(clk), .rst_n(rst_n), .start(start_v[0]), .op(op), .cin(cin),
        .a(a[15:0]), .b(b[15:0]), .busy(busy_v[0]), .done(done_v[0]), .result(res0),
        .cout(cout_v[0]), .ovf(ovf_v[0]), .zero(zero_v[0]), .neg(neg_v[0]));

    seq_addsub_unit #(.WIDTH(16), .DIGIT(1)) u_d1 (
        .clk(clk), .rst_n(rst_n), .start(start_v[1]), .op(op), .cin(cin),
        .a(a[15:0]), .b(b[15:0]), .busy(busy_v[1]), .done(done_v[1]), .result(res1),
        .cout(cout_v[1]), .ovf(ovf_v[1]), .zero(zero_v[1]), .neg(neg_v[1]));

    seq_addsub_unit #(.WIDTH(16), .DIGIT(16)) u_d16 (
        .clk(clk), .rst_n(rst_n), .start(start_v[2]), .op(op), .cin(cin),
        .a(a[15:0]), .b(b[15:0]), .busy(busy_v[2]), .done(done_v[2]), .result(res2),
        .cout(cout_v[2]), .ovf(ovf_v[2]), .zero(zero_v[2]), .neg(neg_v[2]));

    seq_addsub_unit #(.WIDTH(32), .DIGIT(8)) u_w32 (
        .clk(clk), .rst_n(rst_n), .start(start_v[3]), .op(op), .cin(cin),
        .a(a), .b(b), .busy(busy_v[3]), .done(done_v[3]), .result(res3),
        .cout(cout_v[3]), .ovf(ovf_v[3]), .zero(zero_v[3]), .neg(neg_v[3]));

    always_comb begin
        res_k[0] = {16'h0, res0};
        res_k[1] = {16'h0, res1};
        res_k[2] = {16'h0, res2};
        res_k[3] = res3;
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc_cnt = 0;
    always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

    // Independent reference: full-width sum, overflow from operand/result signs
    function automatic exp_t model(int w, logic [1:0] o, logic ci, logic [31:0] x, logic [31:0] y);
        exp_t e;
        logic [32:0] mask, xx, yy, s;
        logic c0;
        mask = (33'd1 << w) - 33'd1;
        xx = {1'b0, x} & mask;
        yy = (o[0] ? ~{1'b0, y} : {1'b0, y}) & mask;
        c0 = o[1] ? ci : o[0];
        s = xx + yy + 33'(c0);
        e.res  = 32'(s & mask);
        e.cout = s[w];
        e.ovf  = (xx[w-1] == yy[w-1]) && (s[w-1] != xx[w-1]);
        e.zero = (e.res == 32'h0);
        e.neg  = s[w-1];
        return e;
    endfunction

    task automatic chk(string tag, logic [31:0] obs, logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    // Drive an op to config k, wait for the accept edge, push the expectation
    task automatic launch(int k, logic [1:0] o, logic ci, logic [31:0] x, logic [31:0] y);
        op = o; cin = ci; a = x; b = y;
        start_v[k] = 1'b1;
        @(posedge clk); #1;
        start_v[k] = 1'b0;
        acc_cyc = cyc_cnt;
        sb.push_back(model(W_CFG[k], o, ci, x, y));
    endtask

    // Wait (bounded) for done on config k, then pop and compare result and flags
    task automatic wait_done(int k, output exp_t e);
        int n;
        n = 0;
        while (!done_v[k] && n < 64) begin
            chk("busy_in_run", 32'(busy_v[k]), 32'd1);
            @(posedge clk); #1;
            n++;
        end
        chk("done_timeout", 32'(done_v[k]), 32'd1);
        e = sb.pop_front();
        if (done_v[k]) begin
            chk("latency", 32'(cyc_cnt - acc_cyc), 32'(N_CFG[k]));
            chk("busy_at_done", 32'(busy_v[k]), 32'd0);
            chk("result", res_k[k], e.res);
            chk("cout", 32'(cout_v[k]), 32'(e.cout));
            chk("ovf", 32'(ovf_v[k]), 32'(e.ovf));
            chk("zero", 32'(zero_v[k]), 32'(e.zero));
            chk("neg", 32'(neg_v[k]), 32'(e.neg));
        end
    endtask

    // Full op followed by one idle cycle: done is one cycle wide, outputs hold
    task automatic run_op(int k, logic [1:0] o, logic ci, logic [31:0] x, logic [31:0] y);
        exp_t e;
        launch(k, o, ci, x, y);
        wait_done(k, e);
        @(posedge clk); #1;
        chk("done_one_cycle", 32'(done_v[k]), 32'd0);
        chk("busy_idle", 32'(busy_v[k]), 32'd0);
        chk("result_hold", res_k[k], e.res);
    endtask

    function automatic logic [31:0] rnd_val();
        case ($urandom_range(0, 7))
            0:       return 32'h0;
            1:       return 32'hFFFF_FFFF;
            2:       return 32'h8000_8000;
            3:       return 32'h7FFF_7FFF;
            default: return $urandom;
        endcase
    endfunction

    initial begin
        exp_t e;
        checks = 0; errors = 0;
        rst_n = 1'b0; start_v = 4'b0; op = 2'b00; cin = 1'b0; a = '0; b = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_busy", 32'(busy_v[0]), 32'd0);
        chk("rst_done", 32'(done_v[0]), 32'd0);
        chk("rst_result", res_k[0], 32'd0);
        chk("rst_flags", {28'h0, cout_v[0], ovf_v[0], zero_v[0], neg_v[0]}, 32'd0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Directed arithmetic cases on the 16/4 configuration
        run_op(0, 2'b00, 1'b0, 32'h1234, 32'h0FF1);
        run_op(0, 2'b01, 1'b0, 32'h0005, 32'h0007);
        run_op(0, 2'b01, 1'b0, 32'h8000, 32'h0001);
        run_op(0, 2'b00, 1'b1, 32'hFFFF, 32'h0001);
        run_op(0, 2'b10, 1'b1, 32'h7FFF, 32'h0000);

        // SBB, then chain a new op in the DONE cycle with no IDLE gap
        launch(0, 2'b11, 1'b0, 32'h0010, 32'h0001);
        wait_done(0, e);
        launch(0, 2'b00, 1'b0, 32'h0101, 32'h0202);
        chk("chain_busy", 32'(busy_v[0]), 32'd1);
        chk("chain_done_low", 32'(done_v[0]), 32'd0);
        chk("chain_result_hold", res_k[0], e.res);
        wait_done(0, e);
        @(posedge clk); #1;

        // start during RUN with different operands is ignored
        launch(0, 2'b00, 1'b0, 32'h1111, 32'h2222);
        op = 2'b01; a = 32'hAAAA; b = 32'h5555; start_v[0] = 1'b1;
        @(posedge clk); #1;
        start_v[0] = 1'b0;
        wait_done(0, e);
        @(posedge clk); #1;

        // Reset mid-RUN: outputs clear at once and the op never completes
        launch(0, 2'b00, 1'b0, 32'h4321, 32'h1111);
        @(posedge clk); #1;
        rst_n = 1'b0;
        #1;
        chk("abort_busy", 32'(busy_v[0]), 32'd0);
        chk("abort_done", 32'(done_v[0]), 32'd0);
        chk("abort_result", res_k[0], 32'd0);
        chk("abort_flags", {28'h0, cout_v[0], ovf_v[0], zero_v[0], neg_v[0]}, 32'd0);
        void'(sb.pop_back());
        @(posedge clk); #1;
        rst_n = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            chk("abort_no_done", 32'(done_v[0]), 32'd0);
        end
        run_op(0, 2'b01, 1'b0, 32'h0003, 32'h0003);

        // Latency boundaries on the serial and single-cycle configurations
        run_op(1, 2'b00, 1'b0, 32'h1234, 32'h0FF1);
        run_op(2, 2'b01, 1'b0, 32'h8000, 32'h0001);
        run_op(3, 2'b10, 1'b1, 32'h7FFF_FFFF, 32'h0000_0000);

        // Random ops against the reference model, every configuration
        for (int k = 0; k < 4; k++) begin
            for (int i = 0; i < 1000; i++) begin
                run_op(k, 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), rnd_val(), rnd_val());
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
